dft_stream_source: RTL and testbench

- Producer end of the DFT accumulation stream interface.
- Accepts I/Q samples from the AFE, fetches the window coefficient h[n] from an external window ROM, and generates the per-bin complex oscillator W[n,k] by recursive rotation.
- Drives start / sample_valid / last_sample to the DFT accumulator with all data mutually aligned.
- One instance per DFT frame engine, sitting between the AFE and the accumulator.

---
 rtl/dft_stream_pkg.sv | 26 ++
 rtl/dft_stream_source_osc_rotator.sv | 48 ++++
 rtl/dft_stream_source.sv | 142 ++++++++++++++
 tb/tb_dft_stream_source.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dft_stream_pkg.sv
// Shared types and fixed-point helpers for the DFT stream source.
package dft_stream_pkg;

    typedef enum logic [1:0] {IDLE, START, RUN, DRAIN} state_t;

    // Unity in Q2.(osc_width-2)
    function automatic logic [63:0] osc_one(input int osc_width);
        return 64'd1 << (osc_width - 2);
    endfunction

    // Clamp a wide signed value into the signed range of 'width' bits
    function automatic logic signed [63:0] sat_signed(input logic signed [127:0] v,
                                                      input int width);
        logic signed [127:0] hi;
        logic signed [127:0] lo;
        hi = (128'sd1 <<< (width - 1)) - 128'sd1;
        lo = -(128'sd1 <<< (width - 1));
        if (v > hi)
            return hi[63:0];
        else if (v < lo)
            return lo[63:0];
        else
            return v[63:0];
    endfunction

endpackage

// File: rtl/dft_stream_source_osc_rotator.sv
// Combinational complex rotation W*R in Q2 fixed point with saturation.
// DFT_STREAM_SOURCE_ROUND_EN selects round-half-up instead of truncation.
module osc_rotator
    import dft_stream_pkg::*;
#(
    parameter int OSC_WIDTH = 27
) (
    input  logic signed [OSC_WIDTH-1:0] w_re_i,
    input  logic signed [OSC_WIDTH-1:0] w_im_i,
    input  logic signed [OSC_WIDTH-1:0] r_re_i,
    input  logic signed [OSC_WIDTH-1:0] r_im_i,
    output logic signed [OSC_WIDTH-1:0] re_o,
    output logic signed [OSC_WIDTH-1:0] im_o
);

    localparam int MW = 2 * OSC_WIDTH;
    localparam int PW = 2 * OSC_WIDTH + 1;
    localparam int SH = OSC_WIDTH - 2;

    logic signed [MW-1:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [PW-1:0] re_full, im_full;
    logic signed [PW-1:0] re_adj, im_adj;
    logic signed [PW-1:0] re_sh, im_sh;

    assign p_rr = MW'(w_re_i) * MW'(r_re_i);
    assign p_ii = MW'(w_im_i) * MW'(r_im_i);
    assign p_ri = MW'(w_re_i) * MW'(r_im_i);
    assign p_ir = MW'(w_im_i) * MW'(r_re_i);

    assign re_full = PW'(p_rr) - PW'(p_ii);
    assign im_full = PW'(p_ri) + PW'(p_ir);

`ifdef DFT_STREAM_SOURCE_ROUND_EN
    localparam logic signed [PW-1:0] HALF = PW'(1) <<< (OSC_WIDTH - 3);
    assign re_adj = re_full + HALF;
    assign im_adj = im_full + HALF;
`else
    assign re_adj = re_full;
    assign im_adj = im_full;
`endif

    assign re_sh = re_adj >>> SH;
    assign im_sh = im_adj >>> SH;

    assign re_o = OSC_WIDTH'(sat_signed(128'(re_sh), OSC_WIDTH));
    assign im_o = OSC_WIDTH'(sat_signed(128'(im_sh), OSC_WIDTH));

endmodule

// File: rtl/dft_stream_source.sv
// Producer end of the DFT accumulation stream: aligns AFE I/Q, window h[n] and
// per-bin oscillator W[n,k]. Rounding mode selected by DFT_STREAM_SOURCE_ROUND_EN.
module dft_stream_source
    import dft_stream_pkg::*;
#(
    parameter int IQ_WIDTH           = 16,
    parameter int WINDOW_WIDTH       = 16,
    parameter int OSC_WIDTH          = 27,
    parameter int NUM_BINS           = 16,
    parameter int SAMPLE_COUNT_WIDTH = 16
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   cfg_start_i,
    input  logic [SAMPLE_COUNT_WIDTH-1:0]          num_samples_i,
    input  logic [NUM_BINS-1:0][OSC_WIDTH-1:0]     rot_real_i,
    input  logic [NUM_BINS-1:0][OSC_WIDTH-1:0]     rot_imag_i,
    input  logic                                   afe_valid_i,
    output logic                                   afe_ready_o,
    input  logic signed [IQ_WIDTH-1:0]             afe_i_i,
    input  logic signed [IQ_WIDTH-1:0]             afe_q_i,
    output logic [SAMPLE_COUNT_WIDTH-1:0]          win_addr_o,
    input  logic signed [WINDOW_WIDTH-1:0]         win_data_i,
    output logic                                   start_o,
    output logic                                   sample_valid_o,
    output logic                                   last_sample_o,
    output logic signed [IQ_WIDTH-1:0]             i_sample_o,
    output logic signed [IQ_WIDTH-1:0]             q_sample_o,
    output logic signed [WINDOW_WIDTH-1:0]         window_coeff_o,
    output logic [NUM_BINS-1:0][OSC_WIDTH-1:0]     W_real_o,
    output logic [NUM_BINS-1:0][OSC_WIDTH-1:0]     W_imag_o,
    output logic                                   busy_o
);

    localparam logic [OSC_WIDTH-1:0] ONE = OSC_WIDTH'(osc_one(OSC_WIDTH));

    state_t                                state_q;
    logic [SAMPLE_COUNT_WIDTH-1:0]         n_q;
    logic [SAMPLE_COUNT_WIDTH-1:0]         n_total_q;
    logic [NUM_BINS-1:0][OSC_WIDTH-1:0]    rot_re_q, rot_im_q;
    logic [NUM_BINS-1:0][OSC_WIDTH-1:0]    w_re_q, w_im_q;
    logic [NUM_BINS-1:0][OSC_WIDTH-1:0]    w_re_nxt, w_im_nxt;
    logic signed [WINDOW_WIDTH-1:0]        win_hold_q;
    logic                                  accept;

    assign accept     = afe_valid_i & afe_ready_o;
    assign win_addr_o = afe_ready_o ? n_q : '0;

    for (genvar k = 0; k < NUM_BINS; k++) begin : g_bin
        osc_rotator #(
            .OSC_WIDTH (OSC_WIDTH)
        ) u_rot (
            .w_re_i (w_re_q[k]),
            .w_im_i (w_im_q[k]),
            .r_re_i (rot_re_q[k]),
            .r_im_i (rot_im_q[k]),
            .re_o   (w_re_nxt[k]),
            .im_o   (w_im_nxt[k])
        );
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            n_q            <= '0;
            n_total_q      <= '0;
            rot_re_q       <= '0;
            rot_im_q       <= '0;
            w_re_q         <= '0;
            w_im_q         <= '0;
            afe_ready_o    <= 1'b0;
            start_o        <= 1'b0;
            sample_valid_o <= 1'b0;
            last_sample_o  <= 1'b0;
            busy_o         <= 1'b0;
            i_sample_o     <= '0;
            q_sample_o     <= '0;
            W_real_o       <= '0;
            W_imag_o       <= '0;
        end else begin
            start_o        <= 1'b0;
            sample_valid_o <= 1'b0;
            last_sample_o  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cfg_start_i && (num_samples_i != '0)) begin
                        state_q   <= START;
                        n_total_q <= num_samples_i;
                        rot_re_q  <= rot_real_i;
                        rot_im_q  <= rot_imag_i;
                        start_o   <= 1'b1;
                        busy_o    <= 1'b1;
                    end
                end
                START: begin
                    for (int k = 0; k < NUM_BINS; k++) begin
                        w_re_q[k] <= ONE;
                        w_im_q[k] <= '0;
                    end
                    n_q         <= '0;
                    afe_ready_o <= 1'b1;
                    state_q     <= RUN;
                end
                RUN: begin
                    // W advances only on accepted samples, so gaps freeze the phase
                    if (accept) begin
                        i_sample_o     <= afe_i_i;
                        q_sample_o     <= afe_q_i;
                        W_real_o       <= w_re_q;
                        W_imag_o       <= w_im_q;
                        w_re_q         <= w_re_nxt;
                        w_im_q         <= w_im_nxt;
                        n_q            <= n_q + 1'b1;
                        sample_valid_o <= 1'b1;
                        if (n_q == n_total_q - 1'b1) begin
                            last_sample_o <= 1'b1;
                            afe_ready_o   <= 1'b0;
                            state_q       <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    busy_o  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // ROM data arrives one cycle after the address, in step with the output stage;
    // the held copy keeps window_coeff_o stable while sample_valid_o is low.
    always_ff @(posedge clk_i) begin
        if (!rst_ni)
            win_hold_q <= '0;
        else if (sample_valid_o)
            win_hold_q <= win_data_i;
    end

    assign window_coeff_o = sample_valid_o ? win_data_i : win_hold_q;

endmodule

// File: tb/tb_dft_stream_source.sv
// Directed bench for dft_stream_source with a 1-cycle-latency window ROM model.
module tb_dft_stream_source;

    localparam int IW = 16;
    localparam int WW = 16;
    localparam int OW = 27;
    localparam int NB = 16;
    localparam int SW = 16;
    localparam longint ONE = 33554432;
    localparam longint MAXP = 67108863;
`ifdef DFT_STREAM_SOURCE_ROUND_EN
    localparam longint E2 = 5;
`else
    localparam longint E2 = 4;
`endif

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic cfg_start = 1'b0;
    logic [SW-1:0] num_samples = '0;
    logic [NB-1:0][OW-1:0] rot_re, rot_im;
    logic afe_valid = 1'b0;
    logic afe_ready_o;
    logic signed [IW-1:0] afe_i = '0, afe_q = '0;
    logic [SW-1:0] win_addr_o;
    logic signed [WW-1:0] win_data = '0;
    logic start_o, sample_valid_o, last_sample_o, busy_o;
    logic signed [IW-1:0] i_sample_o, q_sample_o;
    logic signed [WW-1:0] window_coeff_o;
    logic [NB-1:0][OW-1:0] W_real_o, W_imag_o;

    dft_stream_source #(
        .IQ_WIDTH(IW), .WINDOW_WIDTH(WW), .OSC_WIDTH(OW),
        .NUM_BINS(NB), .SAMPLE_COUNT_WIDTH(SW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .cfg_start_i(cfg_start),
        .num_samples_i(num_samples), .rot_real_i(rot_re), .rot_imag_i(rot_im),
        .afe_valid_i(afe_valid), .afe_ready_o(afe_ready_o),
        .afe_i_i(afe_i), .afe_q_i(afe_q),
        .win_addr_o(win_addr_o), .win_data_i(win_data),
        .start_o(start_o), .sample_valid_o(sample_valid_o),
        .last_sample_o(last_sample_o), .i_sample_o(i_sample_o),
        .q_sample_o(q_sample_o), .window_coeff_o(window_coeff_o),
        .W_real_o(W_real_o), .W_imag_o(W_imag_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) win_data <= WW'(100 + int'(win_addr_o));

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Output monitor: captures every valid beat and checks data hold between beats
    longint q_wr0[$], q_wi0[$], q_wr1[$], q_wr2[$], q_win[$], q_i[$], q_last[$];
    int cyc = 0, start_cnt = 0, start_cyc = -1, first_vld_cyc = -1;
    int last_cyc = -1, busy_fall_cyc = -1, hold_viol = 0;
    logic busy_d = 1'b0, rst_d = 1'b0;
    logic [OW-1:0] prev_wr0 = '0;
    logic [IW-1:0] prev_i = '0;
    logic [WW-1:0] prev_win = '0;

    always @(negedge clk) begin
        cyc++;
        if (start_o) begin start_cnt++; start_cyc = cyc; end
        if (sample_valid_o) begin
            if (first_vld_cyc < 0) first_vld_cyc = cyc;
            q_wr0.push_back(longint'($signed(W_real_o[0])));
            q_wi0.push_back(longint'($signed(W_imag_o[0])));
            q_wr1.push_back(longint'($signed(W_real_o[1])));
            q_wr2.push_back(longint'($signed(W_real_o[2])));
            q_win.push_back(longint'(window_coeff_o));
            q_i.push_back(longint'(i_sample_o));
            q_last.push_back(longint'(last_sample_o));
            if (last_sample_o) last_cyc = cyc;
        end
        if (busy_d && !busy_o) busy_fall_cyc = cyc;
        if (rst_ni && rst_d && !sample_valid_o &&
            (W_real_o[0] !== prev_wr0 || i_sample_o !== prev_i || window_coeff_o !== prev_win))
            hold_viol++;
        prev_wr0 = W_real_o[0];
        prev_i   = i_sample_o;
        prev_win = window_coeff_o;
        busy_d   = busy_o;
        rst_d    = rst_ni;
    end

    task automatic clear_mon();
        q_wr0.delete(); q_wi0.delete(); q_wr1.delete(); q_wr2.delete();
        q_win.delete(); q_i.delete(); q_last.delete();
        start_cnt = 0; start_cyc = -1; first_vld_cyc = -1;
        last_cyc = -1; busy_fall_cyc = -1;
    endtask

    task automatic chk_q(input string tag, input longint got[$], input int n,
                         input longint e0, input longint e1, input longint e2,
                         input longint e3, input longint e4);
        longint e[5];
        e = '{e0, e1, e2, e3, e4};
        chk({tag, "_len"}, got.size(), n);
        for (int i = 0; i < n && i < got.size(); i++)
            chk($sformatf("%s[%0d]", tag, i), got[i], e[i]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int n);
        cfg_start = 1'b1;
        num_samples = SW'(n);
        tick();
        cfg_start = 1'b0;
    endtask

    // Feeds n samples (i = 10k+1, q = -k); optional 0-3 cycle gaps and a stray start pulse
    task automatic feed(input int n, input bit gaps, input bit poke_start);
        int k = 0, gap = 0, guard = 0;
        bit acc;
        while (k < n && guard < 500) begin
            guard++;
            if (gap > 0) begin
                afe_valid = 1'b0;
                gap--;
            end else begin
                afe_valid = 1'b1;
                afe_i = IW'(10 * k + 1);
                afe_q = IW'(-k);
            end
            cfg_start = poke_start && (k == 1);
            acc = afe_valid && afe_ready_o;
            tick();
            if (acc) begin
                k++;
                if (gaps) gap = k % 4;
            end
        end
        afe_valid = 1'b0;
        cfg_start = 1'b0;
        chk("feed_timeout", longint'(guard < 500), 1);
    endtask

    task automatic wait_idle();
        int g = 0;
        while (busy_o && g < 100) begin tick(); g++; end
        chk("idle_timeout", longint'(busy_o), 0);
    endtask

    initial begin
        for (int b = 0; b < NB; b++) begin
            rot_re[b] = OW'(ONE);
            rot_im[b] = '0;
        end
        tick(); tick();
        chk("rst_busy", longint'(busy_o), 0);
        chk("rst_ready", longint'(afe_ready_o), 0);
        chk("rst_valid", longint'(sample_valid_o), 0);
        chk("rst_start", longint'(start_o), 0);
        chk("rst_wr0", longint'(W_real_o[0]), 0);
        rst_ni = 1'b1;
        tick();

        // 1: quarter-turn rotation on bin 0, afe_valid held high
        clear_mon();
        rot_re[0] = '0;
        rot_im[0] = OW'(ONE);
        start_frame(4);
        feed(4, 1'b0, 1'b0);
        wait_idle();
        tick();
        chk("t1_starts", start_cnt, 1);
        chk_q("t1_wr0", q_wr0, 4, ONE, 0, -ONE, 0, 0);
        chk_q("t1_wi0", q_wi0, 4, 0, ONE, 0, -ONE, 0);
        chk_q("t1_last", q_last, 4, 0, 0, 0, 1, 0);
        chk("t1_first_lat", first_vld_cyc - start_cyc, 2);
        chk("t1_busy_fall", busy_fall_cyc - last_cyc, 1);

        // 2/3: small real rotation (rounding visible) and saturating rotation
        clear_mon();
        rot_re[1] = OW'(12288);
        rot_re[2] = OW'(MAXP);
        start_frame(3);
        feed(3, 1'b0, 1'b0);
        wait_idle();
        chk_q("t2_wr1", q_wr1, 3, ONE, 12288, E2, 0, 0);
        chk_q("t3_wr2", q_wr2, 3, ONE, MAXP, MAXP, 0, 0);
        chk_q("t2_last", q_last, 3, 0, 0, 1, 0, 0);

        // 4: valid gaps; window and I/Q aligned, W frozen across gaps
        clear_mon();
        start_frame(5);
        feed(5, 1'b1, 1'b0);
        wait_idle();
        tick();
        chk_q("t4_win", q_win, 5, 100, 101, 102, 103, 104);
        chk_q("t4_i", q_i, 5, 1, 11, 21, 31, 41);
        chk_q("t4_wr1", q_wr1, 5, ONE, 12288, E2, 0, 0);
        chk("t4_hold", hold_viol, 0);

        // 5: start pulse during RUN and a zero-length start in IDLE are ignored
        clear_mon();
        start_frame(3);
        feed(3, 1'b0, 1'b1);
        wait_idle();
        chk("t5_run_start", start_cnt, 1);
        chk("t5_samples", q_i.size(), 3);
        num_samples = '0;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        tick(); tick();
        chk("t5_zero_start", start_cnt, 1);
        chk("t5_zero_busy", longint'(busy_o), 0);

        // 6: reset mid-RUN, then a clean frame restarting from W = ONE
        clear_mon();
        start_frame(8);
        feed(3, 1'b0, 1'b0);
        rst_ni = 1'b0;
        tick();
        chk("t6_valid", longint'(sample_valid_o), 0);
        chk("t6_busy", longint'(busy_o), 0);
        chk("t6_ready", longint'(afe_ready_o), 0);
        chk("t6_last", longint'(last_sample_o), 0);
        chk("t6_wr0", longint'(W_real_o[0]), 0);
        chk("t6_wi0", longint'(W_imag_o[0]), 0);
        chk("t6_i", longint'(i_sample_o), 0);
        chk("t6_win", longint'(window_coeff_o), 0);
        chk("t6_addr", longint'(win_addr_o), 0);
        rst_ni = 1'b1;
        tick();
        chk("t6_no_last", last_cyc, -1);
        clear_mon();
        start_frame(4);
        feed(4, 1'b0, 1'b0);
        wait_idle();
        tick();
        chk_q("t6_wr0", q_wr0, 4, ONE, 0, -ONE, 0, 0);
        chk_q("t6_wi0", q_wi0, 4, 0, ONE, 0, -ONE, 0);
        chk_q("t6_last", q_last, 4, 0, 0, 0, 1, 0);
        chk("end_hold", hold_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=0", cyc);
        $fatal(1, "timeout");
    end

endmodule
